// File: rtl/capsense_pkg.sv
// rtl/capsense_pkg.sv - shared types and constants for the CapSense pad emulator
package capsense_pkg;

  typedef enum logic [1:0] {
    CHARGED   = 2'd0,
    DISCHARGE = 2'd1,
    CHARGING  = 2'd2
  } chan_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form of taps 16,14,13,11 (bits 0,2,3,5 feed the new MSB)
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int DEF_BASE_DLY  = 20;
  localparam int DEF_TOUCH_DLY = 60;
  localparam int DEF_MIN_DIS   = 8;
  localparam int DEF_JIT_W     = 2;
  localparam int DEF_CNT_W     = 16;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/capsense_pad_chan.sv
// rtl/capsense_pad_chan.sv - one emulated pad: discharge tracking and charge-time counter
module capsense_pad_chan
  import capsense_pkg::*;
#(
  parameter int BASE_DLY  = DEF_BASE_DLY,
  parameter int TOUCH_DLY = DEF_TOUCH_DLY,
  parameter int MIN_DIS   = DEF_MIN_DIS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oe_q,
  input  logic             touch,
  input  logic [CNT_W-1:0] jitter,
  output logic             pad
);

  localparam logic [CNT_W-1:0] BASE_C  = CNT_W'(BASE_DLY);
  localparam logic [CNT_W-1:0] TOUCH_C = CNT_W'(TOUCH_DLY);
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_DIS);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  chan_state_e      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] dis_cnt, dis_nx;
  logic [CNT_W-1:0] dly;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dis_nx   = dis_cnt;
    dly      = (touch ? TOUCH_C : BASE_C) + jitter;
    case (state)
      CHARGED: begin
        if (oe_q) begin
          state_nx = DISCHARGE;
          dis_nx   = ONE_C;
        end
      end
      DISCHARGE: begin
        if (oe_q) begin
          if (dis_cnt < MIN_C) dis_nx = dis_cnt + ONE_C;
        end else if (dis_cnt >= MIN_C) begin
          state_nx = CHARGING;
          cnt_nx   = dly - ONE_C;
        end else begin
          state_nx = CHARGED;
        end
      end
      CHARGING: begin
        // A new discharge strobe wins over an expiring charge
        if (oe_q) begin
          state_nx = DISCHARGE;
          dis_nx   = ONE_C;
        end else if (cnt == '0) begin
          state_nx = CHARGED;
        end else begin
          cnt_nx = cnt - ONE_C;
        end
      end
      default: state_nx = CHARGED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CHARGED;
      cnt     <= '0;
      dis_cnt <= '0;
      pad     <= 1'b1;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      dis_cnt <= dis_nx;
      pad     <= (state_nx == CHARGED);
    end
  end

endmodule

// File: rtl/capsense_pad_emu.sv
// rtl/capsense_pad_emu.sv - N-pad CapSense emulator: strobe register, jitter LFSR, pad channels
module capsense_pad_emu
  import capsense_pkg::*;
#(
  parameter int N         = 4,
  parameter int BASE_DLY  = DEF_BASE_DLY,
  parameter int TOUCH_DLY = DEF_TOUCH_DLY,
  parameter int MIN_DIS   = DEF_MIN_DIS,
  parameter int JIT_W     = DEF_JIT_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         capsense_oe,
  input  logic [N-1:0] touch_i,
  output logic [N-1:0] capsense_o
);

  localparam longint MAX_DLY = (BASE_DLY > TOUCH_DLY) ? BASE_DLY : TOUCH_DLY;

  if (BASE_DLY < 1 || TOUCH_DLY < 1) begin : g_bad_dly
    $error("capsense_pad_emu: BASE_DLY and TOUCH_DLY must be at least 1");
  end
  if (N + JIT_W - 1 > 16) begin : g_bad_jit
    $error("capsense_pad_emu: jitter slices exceed the 16-bit LFSR");
  end
  if (MAX_DLY + (64'd1 << JIT_W) - 1 >= (64'd1 << CNT_W)) begin : g_bad_cnt
    $error("capsense_pad_emu: CNT_W too narrow for the longest charge time");
  end

  logic        oe_q;
  logic [15:0] lfsr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      oe_q <= 1'b0;
      lfsr <= LFSR_SEED;
    end else begin
      oe_q <= capsense_oe;
      lfsr <= lfsr_step(lfsr);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    logic [CNT_W-1:0] jitter;

    // Overlapping LFSR windows give each pad its own jitter draw
    if (JIT_W > 0) begin : g_jit
      assign jitter = CNT_W'(lfsr[i+JIT_W-1:i]);
    end else begin : g_nojit
      assign jitter = '0;
    end

    capsense_pad_chan #(
      .BASE_DLY (BASE_DLY),
      .TOUCH_DLY(TOUCH_DLY),
      .MIN_DIS  (MIN_DIS),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk   (clk_i),
      .rst   (rst_i),
      .oe_q  (oe_q),
      .touch (touch_i[i]),
      .jitter(jitter),
      .pad   (capsense_o[i])
    );
  end

endmodule

// File: tb/tb_capsense_pad_emu.sv
// tb/tb_capsense_pad_emu.sv - directed self-checking bench for capsense_pad_emu
module tb_capsense_pad_emu;

  logic       clk = 1'b0;
  logic       rst;
  logic       oe;
  logic       oe_j;
  logic [3:0] touch;
  logic [3:0] touch_j;
  logic [3:0] o;
  logic [3:0] o_j;

  int tests = 0;
  int fails = 0;
  int rise[4];
  bit seen[4];

  always #5 clk = ~clk;

  capsense_pad_emu #(
    .N(4), .BASE_DLY(20), .TOUCH_DLY(60), .MIN_DIS(8), .JIT_W(0), .CNT_W(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .capsense_oe(oe), .touch_i(touch), .capsense_o(o)
  );

  capsense_pad_emu #(
    .N(4), .BASE_DLY(20), .TOUCH_DLY(60), .MIN_DIS(8), .JIT_W(2), .CNT_W(16)
  ) dut_j (
    .clk_i(clk), .rst_i(rst), .capsense_oe(oe_j), .touch_i(touch_j), .capsense_o(o_j)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called right after a negedge; strobe is sampled high on exactly hi rising edges
  task automatic drive_oe(input int hi, input bit sel);
    if (sel) oe_j = 1'b1; else oe = 1'b1;
    repeat (hi) @(negedge clk);
    if (sel) oe_j = 1'b0; else oe = 1'b0;
  endtask

  // rise[b] = index j of the first edge k+j after which pad b reads 1 (edge k samples oe low)
  task automatic measure(input bit sel, input bit toggle);
    logic [3:0] v;
    for (int b = 0; b < 4; b++) rise[b] = -1;
    for (int j = 0; j <= 100; j++) begin
      @(negedge clk);
      v = sel ? o_j : o;
      for (int b = 0; b < 4; b++) if (v[b] && rise[b] < 0) rise[b] = j;
      if (toggle && j == 5) touch = ~touch;
      if (&v) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; oe = 1'b0; oe_j = 1'b0; touch = 4'b0000; touch_j = 4'b0000;
    #1;
    check("reset_async", o, 4'hF);
    repeat (2) @(negedge clk);
    check("reset_hold", o, 4'hF);
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check("idle_high", o, 4'hF);
    end

    // Untouched full discharge, including strobe-to-output latency
    oe = 1'b1;
    @(negedge clk);
    check("oe_lat_edge1", o, 4'hF);
    @(negedge clk);
    check("oe_lat_edge2", o, 4'h0);
    repeat (8) @(negedge clk);
    oe = 1'b0;
    measure(0, 0);
    for (int b = 0; b < 4; b++) check($sformatf("untouched_rise%0d", b), rise[b], 21);

    // Mixed touch, touch toggled mid-charge must not matter
    touch = 4'b0101;
    drive_oe(10, 0);
    measure(0, 1);
    check("mixed_rise0", rise[0], 61);
    check("mixed_rise1", rise[1], 21);
    check("mixed_rise2", rise[2], 61);
    check("mixed_rise3", rise[3], 21);
    touch = 4'b0000;
    @(negedge clk);

    // Partial discharge and the MIN_DIS boundary
    drive_oe(3, 0);
    measure(0, 0);
    for (int b = 0; b < 4; b++) check($sformatf("partial3_rise%0d", b), rise[b], 1);
    drive_oe(7, 0);
    measure(0, 0);
    check("partial7_rise0", rise[0], 1);
    drive_oe(8, 0);
    measure(0, 0);
    check("exact_min_rise0", rise[0], 21);
    check("exact_min_rise3", rise[3], 21);

    // Re-discharge 5 cycles into charging
    drive_oe(10, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("recharge_low", o, 4'h0);
    end
    oe = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("redis_low", o, 4'h0);
    end
    oe = 1'b0;
    measure(0, 0);
    check("redis_rise0", rise[0], 21);
    check("redis_rise2", rise[2], 21);

    // Asynchronous reset mid-charge
    drive_oe(10, 0);
    repeat (5) @(negedge clk);
    check("pre_rst_low", o, 4'h0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_charge", o, 4'hF);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_1", o, 4'hF);
    @(negedge clk);
    check("post_rst_2", o, 4'hF);

    // Jitter instance: charge time per pad within 20..23, all four values seen
    for (int it = 0; it < 30; it++) begin
      drive_oe(8 + (it % 4), 1);
      measure(1, 0);
      for (int b = 0; b < 4; b++) begin
        int d;
        d = rise[b] - 1;
        check($sformatf("jit_range_it%0d_ch%0d", it, b), (d >= 20 && d <= 23), 1);
        if (d >= 20 && d <= 23) seen[d-20] = 1'b1;
      end
      repeat (1 + (it % 3)) @(negedge clk);
    end
    for (int v = 0; v < 4; v++) check($sformatf("jit_seen_%0d", 20 + v), seen[v], 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
